// File: rtl/fc_argmax.sv
// fc_argmax: serial argmax head for the packed output vector of a fully connected
// layer. An accepted vector is copied into a private register. The block then
// walks that copy one element per cycle through a single signed comparator. When
// the walk ends it holds the index of the largest logit, and the value too when
// enabled, behind a valid/ready handshake.
//
// Optional feature: define FC_ARGMAX_SCORE_EN to add the `score` output port.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in         packed logits, element k at in[k*data_size +: data_size]
//   in_valid   `in` holds a vector
//   in_ready   vector can be accepted this cycle (IDLE and not in reset)
//   class_idx  index of the largest logit; lower index wins a tie
//   out_valid  result is presented
//   out_ready  consumer takes the result this cycle
//   score      largest logit value (FC_ARGMAX_SCORE_EN only)
//
// state | meaning
// IDLE  | waiting for a vector, in_ready high
// SCAN  | comparing element cnt against the running best
// DONE  | result presented, held until out_ready

module fc_argmax #(
   parameter int out_features = 10,
   parameter int data_size    = 8,
   localparam int IDX_W       = (out_features > 1) ? $clog2(out_features) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [out_features*data_size-1:0] in,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [IDX_W-1:0]                  class_idx,
   output logic                              out_valid,
   input  logic                              out_ready
`ifdef FC_ARGMAX_SCORE_EN
   ,
   output logic [data_size-1:0]              score
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(out_features - 1);

   state_t                state;
   state_t                state_next;
   logic [data_size-1:0]  vec [out_features];
   logic [data_size-1:0]  best_val;
   logic [IDX_W-1:0]      best_idx;
   logic [IDX_W-1:0]      cnt;
   logic                  accept;
   logic                  last;

   assign accept = in_valid && in_ready;
   assign last   = (cnt == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // in_ready is gated by rst so a vector offered during reset is never taken.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !rst;
            if (accept) begin
               state_next = (out_features == 1) ? DONE : SCAN;
            end
         end
         SCAN: begin
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Element 0 seeds the running best at accept time, so the scan starts at 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         best_val <= '0;
         best_idx <= '0;
         cnt      <= '0;
      end else if (accept) begin
         for (int k = 0; k < out_features; k++) begin
            vec[k] <= in[k*data_size +: data_size];
         end
         best_val <= in[data_size-1:0];
         best_idx <= '0;
         cnt      <= IDX_W'(1);
      end else if (state == SCAN) begin
         // Strict compare: a later equal value never displaces an earlier one.
         if ($signed(vec[cnt]) > $signed(best_val)) begin
            best_val <= vec[cnt];
            best_idx <= cnt;
         end
         if (!last) begin
            cnt <= cnt + IDX_W'(1);
         end
      end
   end

   assign class_idx = best_idx;
`ifdef FC_ARGMAX_SCORE_EN
   assign score     = best_val;
`endif

endmodule

// File: tb/tb_fc_argmax.sv
module tb_fc_argmax;

   localparam int N4 = 4;
   localparam int N1 = 1;
   localparam int DW = 8;

   typedef struct {
      int idx;
      int sc;
      int due;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   int                cyc = 0;
   int                checks = 0;
   int                errors = 0;
   bit                rnd_rdy = 1'b0;

   logic [N4*DW-1:0]  in_a;
   logic              iv_a, in_ready_a, ov_a, ordy_a;
   logic [1:0]        idx_a;
   logic [N1*DW-1:0]  in_b;
   logic              iv_b, in_ready_b, ov_b, ordy_b;
   logic [0:0]        idx_b;
`ifdef FC_ARGMAX_SCORE_EN
   logic [DW-1:0]     score_a, score_b;
`endif

   exp_t qa[$];
   exp_t qb[$];

   fc_argmax #(.out_features(N4), .data_size(DW)) u_dut4 (
      .clk(clk), .rst(rst), .in(in_a), .in_valid(iv_a), .in_ready(in_ready_a),
      .class_idx(idx_a), .out_valid(ov_a), .out_ready(ordy_a)
`ifdef FC_ARGMAX_SCORE_EN
      , .score(score_a)
`endif
   );

   fc_argmax #(.out_features(N1), .data_size(DW)) u_dut1 (
      .clk(clk), .rst(rst), .in(in_b), .in_valid(iv_b), .in_ready(in_ready_b),
      .class_idx(idx_b), .out_valid(ov_b), .out_ready(ordy_b)
`ifdef FC_ARGMAX_SCORE_EN
      , .score(score_b)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: find the maximum signed value, then the first position holding it.
   function automatic void ref_argmax(input logic [31:0] v, input int n,
                                      output int idx, output int sc);
      int mx;
      int val;
      mx  = -1000;
      idx = -1;
      for (int k = 0; k < n; k++) begin
         val = $signed(v[k*8 +: 8]);
         if (val > mx) mx = val;
      end
      for (int k = n - 1; k >= 0; k--) begin
         val = $signed(v[k*8 +: 8]);
         if (val == mx) idx = k;
      end
      sc = mx & 8'hFF;
   endfunction

   function automatic logic [7:0] rnd_elem();
      logic [7:0] e;
      case ($urandom % 4)
         0: e = 8'h80;
         1: e = 8'h7F;
         2: e = 8'($urandom_range(0, 3));
         default: e = 8'($urandom);
      endcase
      return e;
   endfunction

   // Offer a vector at a negedge once in_ready is up; expected result is queued
   // with the cycle in which out_valid must first be seen.
   task automatic send_a(input logic [31:0] v, input bit use_model, input int xi, input int xs);
      exp_t e;
      int   w = 0;
      @(negedge clk);
      while (!in_ready_a && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("accept_timeout_a", in_ready_a, 1);
      if (!in_ready_a) return;
      if (use_model) ref_argmax(v, N4, e.idx, e.sc);
      else begin
         e.idx = xi;
         e.sc  = xs;
      end
      e.due = cyc + N4;
      qa.push_back(e);
      in_a = v;
      iv_a = 1'b1;
      @(posedge clk);
      #1;
      iv_a = 1'b0;
      in_a = $urandom;
   endtask

   task automatic send_b(input logic [7:0] v, input bit use_model, input int xi, input int xs);
      exp_t e;
      int   w = 0;
      @(negedge clk);
      while (!in_ready_b && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("accept_timeout_b", in_ready_b, 1);
      if (!in_ready_b) return;
      if (use_model) ref_argmax({24'h0, v}, N1, e.idx, e.sc);
      else begin
         e.idx = xi;
         e.sc  = xs;
      end
      e.due = cyc + N1;
      qb.push_back(e);
      in_b = v;
      iv_b = 1'b1;
      @(posedge clk);
      #1;
      iv_b = 1'b0;
      in_b = $urandom;
   endtask

   task automatic drain(input int lim);
      int w = 0;
      while ((qa.size() != 0 || qb.size() != 0) && w < lim) begin
         @(negedge clk);
         w++;
      end
      chk("drain_a", qa.size(), 0);
      chk("drain_b", qb.size(), 0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_rdy) begin
            ordy_a = ($urandom % 4) != 0;
            ordy_b = ($urandom % 3) != 0;
         end
      end
   end

   // Monitor for the 4-logit instance.
   bit         ov_p_a = 0, or_p_a = 0;
   int         idx_p_a, sc_p_a;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         ov_p_a = 0;
         or_p_a = 0;
      end else begin
         if (ov_p_a && or_p_a) begin
            chk("handoff_in_ready_a", in_ready_a, 1);
            chk("handoff_valid_low_a", ov_a, 0);
         end
         if (ov_p_a && !or_p_a) begin
            chk("hold_valid_a", ov_a, 1);
            chk("hold_idx_a", idx_a, idx_p_a);
`ifdef FC_ARGMAX_SCORE_EN
            chk("hold_score_a", score_a, sc_p_a);
`endif
         end
         if (ov_a && !ov_p_a) begin
            chk("valid_has_pending_a", qa.size() > 0, 1);
            if (qa.size() > 0) chk("latency_a", cyc, qa[0].due);
         end
         if (ov_a) chk("in_ready_low_in_done_a", in_ready_a, 0);
         if (ov_a && ordy_a && qa.size() > 0) begin
            e = qa.pop_front();
            chk("class_idx_a", idx_a, e.idx);
`ifdef FC_ARGMAX_SCORE_EN
            chk("score_a", score_a, e.sc);
`endif
         end
         ov_p_a  = ov_a;
         or_p_a  = ordy_a;
         idx_p_a = idx_a;
`ifdef FC_ARGMAX_SCORE_EN
         sc_p_a  = score_a;
`endif
      end
   end

   // Monitor for the single-logit instance.
   bit         ov_p_b = 0, or_p_b = 0;
   int         idx_p_b;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         ov_p_b = 0;
         or_p_b = 0;
      end else begin
         if (ov_p_b && or_p_b) begin
            chk("handoff_in_ready_b", in_ready_b, 1);
            chk("handoff_valid_low_b", ov_b, 0);
         end
         if (ov_p_b && !or_p_b) begin
            chk("hold_valid_b", ov_b, 1);
            chk("hold_idx_b", idx_b, idx_p_b);
         end
         if (ov_b && !ov_p_b) begin
            chk("valid_has_pending_b", qb.size() > 0, 1);
            if (qb.size() > 0) chk("latency_b", cyc, qb[0].due);
         end
         if (ov_b) chk("in_ready_low_in_done_b", in_ready_b, 0);
         if (ov_b && ordy_b && qb.size() > 0) begin
            e = qb.pop_front();
            chk("class_idx_b", idx_b, e.idx);
`ifdef FC_ARGMAX_SCORE_EN
            chk("score_b", score_b, e.sc);
`endif
         end
         ov_p_b  = ov_b;
         or_p_b  = ordy_b;
         idx_p_b = idx_b;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout actual=%0d expected=0", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      int w;
      rst    = 1'b1;
      iv_a   = 1'b1;
      iv_b   = 1'b1;
      in_a   = 32'h01020304;
      in_b   = 8'h11;
      ordy_a = 1'b1;
      ordy_b = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("in_ready_during_rst_a", in_ready_a, 0);
      chk("in_ready_during_rst_b", in_ready_b, 0);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      iv_a = 1'b0;
      iv_b = 1'b0;
      @(negedge clk);
      chk("rst_in_ready_a", in_ready_a, 1);
      chk("rst_out_valid_a", ov_a, 0);
      chk("rst_class_idx_a", idx_a, 0);
      chk("rst_in_ready_b", in_ready_b, 1);
      chk("rst_out_valid_b", ov_b, 0);
`ifdef FC_ARGMAX_SCORE_EN
      chk("rst_score_a", score_a, 0);
      chk("rst_score_b", score_b, 0);
`endif

      // Directed vectors with out_ready held high; element 0 in the low byte.
      send_a(32'h05FD0702, 1'b0, 1, 8'h07);
      send_a(32'h10101010, 1'b0, 0, 8'h10);
      send_a(32'h01090903, 1'b0, 1, 8'h09);
      send_a(32'h9CFEFF80, 1'b0, 1, 8'hFF);
      drain(50);

      // Backpressure: stall in DONE for three cycles while in/in_valid wiggle.
      ordy_a = 1'b0;
      send_a(32'h3F7F2000, 1'b0, 2, 8'h7F);
      w = 0;
      while (!ov_a && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("bp_reach_done", ov_a, 1);
      repeat (3) begin
         @(posedge clk);
         #1;
         iv_a = 1'($urandom);
         in_a = $urandom;
      end
      @(posedge clk);
      #1;
      iv_a   = 1'b0;
      ordy_a = 1'b1;
      drain(20);
      @(negedge clk);
      chk("bp_no_extra_capture", ov_a, 0);

      // Reset two cycles after accept, with in_valid offered during reset.
      send_a(32'h7F000000, 1'b0, 3, 8'h7F);
      @(posedge clk);
      #1;
      rst  = 1'b1;
      iv_a = 1'b1;
      in_a = 32'h00000055;
      qa.delete();
      @(negedge clk);
      chk("mid_rst_out_valid", ov_a, 0);
      chk("mid_rst_class_idx", idx_a, 0);
      chk("mid_rst_in_ready", in_ready_a, 0);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      iv_a = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (ov_a) seen++;
      end
      chk("no_valid_after_rst", seen, 0);
      send_a(32'h04000000, 1'b0, 3, 8'h04);
      drain(50);

      // Single-logit instance.
      send_b(8'hFB, 1'b0, 0, 8'hFB);
      drain(20);

      // Randomized traffic with random backpressure on both instances.
      rnd_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send_a({rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem()}, 1'b1, 0, 0);
         if ((i % 3) == 0) send_b(rnd_elem(), 1'b1, 0, 0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      drain(200);
      rnd_rdy = 1'b0;
      #1;
      ordy_a = 1'b1;
      ordy_b = 1'b1;
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
